// File: rtl/wb_pkg.sv
// Shared constants and helpers for the write-back arbiter.
// Helpers work at the widest supported address width; callers cast to their own width.
package wb_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 3;
  localparam int REG_AW_MAX = 8;
  localparam int REQ_ALU    = 0;
  localparam int REQ_LD     = 1;

  function automatic logic [REG_AW_MAX-1:0] sel_dst(
    input logic [REG_AW_MAX-1:0] rs,
    input logic [REG_AW_MAX-1:0] rd,
    input logic                  sel
  );
    return sel ? rd : rs;
  endfunction

  function automatic logic [2**REG_AW_MAX-1:0] onehot(input logic [REG_AW_MAX-1:0] addr);
    logic [2**REG_AW_MAX-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/wb_slot.sv
// Single-entry holding register for one write-back requester.
module wb_slot
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  output logic              ready,
  input  logic [REG_AW-1:0] dst,
  input  logic [DATA_W-1:0] data,
  input  logic              grant,
  output logic              full,
  output logic [REG_AW-1:0] q_dst,
  output logic [DATA_W-1:0] q_data
);
  // A granted entry leaves on this edge, so a new one can land on the same edge.
  assign ready = !rst && (!full || grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full   <= 1'b0;
      q_dst  <= '0;
      q_data <= '0;
    end else if (valid && ready) begin
      full   <= 1'b1;
      q_dst  <= dst;
      q_data <= data;
    end else if (grant) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: two buffered requesters share one registered register-file write port.
// Load has priority; the ALU is forced through after STARVE_MAX consecutive losses.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_AW     = REG_AW_DEF,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_AW-1:0]    alu_rs,
  input  logic [REG_AW-1:0]    alu_rd,
  input  logic                 alu_sel,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [REG_AW-1:0]    ld_rs,
  input  logic [REG_AW-1:0]    ld_rd,
  input  logic                 ld_sel,
  input  logic [DATA_W-1:0]    ld_data,
  output logic                 rf_we,
  output logic [REG_AW-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [2**REG_AW-1:0] pend_mask
);
  localparam int NREG = 2**REG_AW;
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [1:0]        valid, ready, full, grant;
  logic [REG_AW-1:0] in_dst [2];
  logic [DATA_W-1:0] in_data[2];
  logic [REG_AW-1:0] q_dst  [2];
  logic [DATA_W-1:0] q_data [2];
  logic [2:0]        starve_cnt;

  assign valid[REQ_ALU]   = alu_valid;
  assign valid[REQ_LD]    = ld_valid;
  assign in_dst[REQ_ALU]  = REG_AW'(sel_dst(REG_AW_MAX'(alu_rs), REG_AW_MAX'(alu_rd), alu_sel));
  assign in_dst[REQ_LD]   = REG_AW'(sel_dst(REG_AW_MAX'(ld_rs), REG_AW_MAX'(ld_rd), ld_sel));
  assign in_data[REQ_ALU] = alu_data;
  assign in_data[REQ_LD]  = ld_data;
  assign alu_ready        = ready[REQ_ALU];
  assign ld_ready         = ready[REQ_LD];

  for (genvar i = 0; i < 2; i++) begin : g_slot
    wb_slot #(
      .DATA_W(DATA_W),
      .REG_AW(REG_AW)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .valid (valid[i]),
      .ready (ready[i]),
      .dst   (in_dst[i]),
      .data  (in_data[i]),
      .grant (grant[i]),
      .full  (full[i]),
      .q_dst (q_dst[i]),
      .q_data(q_data[i])
    );
  end

  always_comb begin
    grant = '0;
    if (full[REQ_LD] && (!full[REQ_ALU] || starve_cnt != STARVE_LIM)) begin
      grant[REQ_LD] = 1'b1;
    end else if (full[REQ_ALU]) begin
      grant[REQ_ALU] = 1'b1;
    end
  end

  // Counts only losses while the ALU actually has something waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!full[REQ_ALU] || grant[REQ_ALU]) begin
      starve_cnt <= '0;
    end else if (grant[REQ_LD] && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= |grant;
      if (grant[REQ_LD]) begin
        rf_waddr <= q_dst[REQ_LD];
        rf_wdata <= q_data[REQ_LD];
      end else if (grant[REQ_ALU]) begin
        rf_waddr <= q_dst[REQ_ALU];
        rf_wdata <= q_data[REQ_ALU];
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < 2; i++) begin
      if (full[i]) pend_mask |= NREG'(onehot(REG_AW_MAX'(q_dst[i])));
    end
    if (rf_we) pend_mask |= NREG'(onehot(REG_AW_MAX'(rf_waddr)));
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int NR   = 8;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, alu_ready, alu_sel;
  logic [AW-1:0] alu_rs, alu_rd;
  logic [DW-1:0] alu_data;
  logic          ld_valid, ld_ready, ld_sel;
  logic [AW-1:0] ld_rs, ld_rd;
  logic [DW-1:0] ld_data;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [NR-1:0] pend_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .DATA_W(DW),
    .REG_AW(AW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_rs   (alu_rs),
    .alu_rd   (alu_rd),
    .alu_sel  (alu_sel),
    .alu_data (alu_data),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_rs    (ld_rs),
    .ld_rd    (ld_rd),
    .ld_sel   (ld_sel),
    .ld_data  (ld_data),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .pend_mask(pend_mask)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one-deep queues per requester ----------------
  typedef struct {
    int dst;
    int data;
  } ent_t;

  ent_t mq_alu[$];
  ent_t mq_ld[$];
  int   m_loss;
  bit   m_we;
  int   m_waddr, m_wdata;

  function automatic void m_reset();
    mq_alu.delete();
    mq_ld.delete();
    m_loss  = 0;
    m_we    = 0;
    m_waddr = 0;
    m_wdata = 0;
  endfunction

  // 1 = load wins, 0 = ALU wins, -1 = nothing to write
  function automatic int m_winner();
    if (mq_ld.size() != 0 && (mq_alu.size() == 0 || m_loss < SMAX)) return 1;
    if (mq_alu.size() != 0) return 0;
    return -1;
  endfunction

  function automatic int m_mask();
    int m = 0;
    foreach (mq_alu[i]) m |= 1 << mq_alu[i].dst;
    foreach (mq_ld[i])  m |= 1 << mq_ld[i].dst;
    if (m_we) m |= 1 << m_waddr;
    return m;
  endfunction

  task automatic rnd_cycle();
    int   w;
    bit   ra, rl, a_had;
    ent_t e;
    w     = m_winner();
    ra    = (mq_alu.size() == 0) || (w == 0);
    rl    = (mq_ld.size() == 0) || (w == 1);
    a_had = (mq_alu.size() != 0);
    chk("rnd_alu_ready", 32'(alu_ready), 32'(ra));
    chk("rnd_ld_ready", 32'(ld_ready), 32'(rl));
    chk("rnd_pend_mask", 32'(pend_mask), m_mask());
    @(posedge clk);
    if (w == 1) begin
      e = mq_ld.pop_front();
      m_we = 1; m_waddr = e.dst; m_wdata = e.data;
    end else if (w == 0) begin
      e = mq_alu.pop_front();
      m_we = 1; m_waddr = e.dst; m_wdata = e.data;
    end else begin
      m_we = 0;
    end
    if (!a_had || w == 0) m_loss = 0;
    else if (w == 1 && m_loss < SMAX) m_loss++;
    if (alu_valid && ra) mq_alu.push_back('{alu_sel ? int'(alu_rd) : int'(alu_rs), int'(alu_data)});
    if (ld_valid && rl)  mq_ld.push_back('{ld_sel ? int'(ld_rd) : int'(ld_rs), int'(ld_data)});
    #1;
    chk("rnd_rf_we", 32'(rf_we), 32'(m_we));
    chk("rnd_rf_waddr", 32'(rf_waddr), m_waddr);
    chk("rnd_rf_wdata", 32'(rf_wdata), m_wdata);
    // requesters keep a pending request stable until it is taken
    if (!alu_valid || ra) begin
      alu_valid = ($urandom_range(9) < 6);
      alu_rs    = AW'($urandom);
      alu_rd    = AW'($urandom);
      alu_sel   = 1'($urandom);
      alu_data  = DW'($urandom);
    end
    if (!ld_valid || rl) begin
      ld_valid = ($urandom_range(9) < 8);
      ld_rs    = AW'($urandom);
      ld_rd    = AW'($urandom);
      ld_sel   = 1'($urandom);
      ld_data  = DW'($urandom);
    end
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          av;
    logic [AW-1:0] ars, ard;
    logic          asel;
    logic [DW-1:0] adat;
    logic          lv;
    logic [AW-1:0] lrs, lrd;
    logic          lsel;
    logic [DW-1:0] ldat;
    logic [NR-1:0] m0, m1, m2;
    logic          we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          we2;
    logic [AW-1:0] a2;
    logic [DW-1:0] d2;
  } vec_t;

  vec_t vt[5];

  initial begin
    int k;
    logic [DW-1:0] sd[5];
    logic [AW-1:0] sa[5];

    vt[0] = '{1'b1, 3'd2, 3'd5, 1'b1, 16'h1234, 1'b0, 3'd0, 3'd0, 1'b0, 16'h0000,
              8'h20, 8'h20, 8'h00, 1'b1, 3'd5, 16'h1234, 1'b0, 3'd5, 16'h1234};
    vt[1] = '{1'b1, 3'd2, 3'd5, 1'b0, 16'h4321, 1'b0, 3'd0, 3'd0, 1'b0, 16'h0000,
              8'h04, 8'h04, 8'h00, 1'b1, 3'd2, 16'h4321, 1'b0, 3'd2, 16'h4321};
    vt[2] = '{1'b1, 3'd3, 3'd0, 1'b0, 16'hAAAA, 1'b1, 3'd1, 3'd4, 1'b1, 16'h5555,
              8'h18, 8'h18, 8'h08, 1'b1, 3'd4, 16'h5555, 1'b1, 3'd3, 16'hAAAA};
    vt[3] = '{1'b0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b1, 3'd7, 3'd1, 1'b0, 16'hBEEF,
              8'h80, 8'h80, 8'h00, 1'b1, 3'd7, 16'hBEEF, 1'b0, 3'd7, 16'hBEEF};
    vt[4] = '{1'b1, 3'd0, 3'd6, 1'b1, 16'h0002, 1'b1, 3'd6, 3'd2, 1'b0, 16'h0001,
              8'h40, 8'h40, 8'h40, 1'b1, 3'd6, 16'h0001, 1'b1, 3'd6, 16'h0002};

    rst = 1'b1;
    alu_valid = 1'b0; alu_rs = '0; alu_rd = '0; alu_sel = 1'b0; alu_data = '0;
    ld_valid  = 1'b0; ld_rs  = '0; ld_rd  = '0; ld_sel  = 1'b0; ld_data  = '0;

    // reset state
    #12;
    chk("rst_alu_ready", 32'(alu_ready), 0);
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_rf_waddr", 32'(rf_waddr), 0);
    chk("rst_rf_wdata", 32'(rf_wdata), 0);
    chk("rst_pend_mask", 32'(pend_mask), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_alu_ready", 32'(alu_ready), 1);
    chk("rel_ld_ready", 32'(ld_ready), 1);
    @(negedge clk);

    // table: one request pair from an idle arbiter, then two commit edges and a drain edge
    for (int i = 0; i < 5; i++) begin
      alu_valid = vt[i].av; alu_rs = vt[i].ars; alu_rd = vt[i].ard; alu_sel = vt[i].asel; alu_data = vt[i].adat;
      ld_valid  = vt[i].lv; ld_rs  = vt[i].lrs; ld_rd  = vt[i].lrd; ld_sel  = vt[i].lsel; ld_data  = vt[i].ldat;
      chk($sformatf("v%0d_idle_ready", i), 32'({alu_ready, ld_ready}), 32'h3);
      @(posedge clk); #1;
      alu_valid = 1'b0; ld_valid = 1'b0;
      chk($sformatf("v%0d_mask0", i), 32'(pend_mask), 32'(vt[i].m0));
      chk($sformatf("v%0d_we0", i), 32'(rf_we), 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_we1", i), 32'(rf_we), 32'(vt[i].we1));
      chk($sformatf("v%0d_addr1", i), 32'(rf_waddr), 32'(vt[i].a1));
      chk($sformatf("v%0d_data1", i), 32'(rf_wdata), 32'(vt[i].d1));
      chk($sformatf("v%0d_mask1", i), 32'(pend_mask), 32'(vt[i].m1));
      @(posedge clk); #1;
      chk($sformatf("v%0d_we2", i), 32'(rf_we), 32'(vt[i].we2));
      chk($sformatf("v%0d_addr2", i), 32'(rf_waddr), 32'(vt[i].a2));
      chk($sformatf("v%0d_data2", i), 32'(rf_wdata), 32'(vt[i].d2));
      chk($sformatf("v%0d_mask2", i), 32'(pend_mask), 32'(vt[i].m2));
      @(posedge clk); #1;
      chk($sformatf("v%0d_drain_we", i), 32'(rf_we), 0);
      chk($sformatf("v%0d_drain_mask", i), 32'(pend_mask), 0);
      @(negedge clk);
    end

    // back-to-back load stream, dst 0..7
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        ld_valid = 1'b1; ld_rs = AW'(c); ld_rd = '0; ld_sel = 1'b0; ld_data = DW'(16'h0100 + c);
        chk($sformatf("tp_ld_ready_%0d", c), 32'(ld_ready), 1);
      end else begin
        ld_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (c >= 1 && c <= 8) begin
        chk($sformatf("tp_we_%0d", c), 32'(rf_we), 1);
        chk($sformatf("tp_addr_%0d", c), 32'(rf_waddr), c - 1);
        chk($sformatf("tp_data_%0d", c), 32'(rf_wdata), 32'h0100 + c - 1);
      end else if (c == 9) begin
        chk("tp_we_end", 32'(rf_we), 0);
      end
      @(negedge clk);
    end

    // starvation: ALU holds one entry while loads arrive every cycle
    sa = '{3'd2, 3'd2, 3'd2, 3'd1, 3'd2};
    sd = '{16'h1000, 16'h1001, 16'h1002, 16'hA1A1, 16'h1003};
    alu_valid = 1'b1; alu_rs = 3'd1; alu_rd = 3'd0; alu_sel = 1'b0; alu_data = 16'hA1A1;
    ld_valid  = 1'b1; ld_rs  = 3'd2; ld_rd  = 3'd0; ld_sel  = 1'b0; ld_data  = 16'h1000;
    @(posedge clk); #1;
    alu_valid = 1'b0;
    k = 1;
    ld_data = DW'(16'h1000 + k);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("st_alu_ready_%0d", c), 32'(alu_ready), (c >= 3) ? 1 : 0);
      chk($sformatf("st_ld_ready_%0d", c), 32'(ld_ready), (c == 3) ? 0 : 1);
      @(posedge clk); #1;
      chk($sformatf("st_we_%0d", c), 32'(rf_we), 1);
      chk($sformatf("st_addr_%0d", c), 32'(rf_waddr), 32'(sa[c]));
      chk($sformatf("st_data_%0d", c), 32'(rf_wdata), 32'(sd[c]));
      if (c != 3) begin
        k++;
        ld_data = DW'(16'h1000 + k);
      end
    end
    ld_valid = 1'b0;
    @(posedge clk); #1;
    chk("st_tail_data", 32'(rf_wdata), 32'h1004);
    repeat (2) @(posedge clk);
    #1;
    chk("st_idle_mask", 32'(pend_mask), 0);
    @(negedge clk);

    // asynchronous reset with both slots full and a write on the port
    alu_valid = 1'b1; alu_rs = 3'd1; alu_sel = 1'b0; alu_data = 16'h0A0A;
    ld_valid  = 1'b1; ld_rs  = 3'd2; ld_sel  = 1'b0; ld_data  = 16'h0B0B;
    @(posedge clk); #1;
    alu_valid = 1'b0; ld_rs = 3'd3; ld_data = 16'h0C0C;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    chk("mr_pre_we", 32'(rf_we), 1);
    chk("mr_pre_mask", 32'(pend_mask), 32'h0E);
    #2 rst = 1'b1;
    #1;
    chk("mr_rf_we", 32'(rf_we), 0);
    chk("mr_mask", 32'(pend_mask), 0);
    chk("mr_ready", 32'({alu_ready, ld_ready}), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("mr_post_we_%0d", c), 32'(rf_we), 0);
      chk($sformatf("mr_post_mask_%0d", c), 32'(pend_mask), 0);
      chk($sformatf("mr_post_ready_%0d", c), 32'({alu_ready, ld_ready}), 32'h3);
    end

    // randomized traffic against the reference model
    m_reset();
    @(negedge clk);
    for (int n = 0; n < 1500; n++) rnd_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
